mod4_step_ctrl: RTL and testbench
=================================

# mod4_step_ctrl

Step controller for the 2-bit mod-4 counter: generates the counter's INC strobe from three sources (a synchronized push-button, a free-running prescaled tick, and a "go to target" seek command) and keeps a shadow copy of the count. It sits between board inputs and the counter's INC input. The counter's Reset is driven from the same Reset, so the shadow count and the counter always agree.

## Interface
- TICK_DIV, 4, clock cycles per step in run mode; use 4 in simulation and the board-rate value in hardware; minimum 2.
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Btn  in  1  raw, asynchronous push-button; a rising edge requests one step.
- Run  in  1  level input; high selects free-run stepping.
- Goto  in  1  one-cycle synchronous pulse; starts a seek to Target.
- Target  in  2  seek destination, sampled with Goto.
- INC  out  1  step strobe to the counter; each cycle it is high advances the count by exactly 1 (mod 4).
- Q  out  2  shadow count; equals the counter's {Q1,Q0}.
- Busy  out  1  high while in SEEK.
- Done  out  1  one-cycle pulse when a seek completes.

## Operation
- States: IDLE, RUN, SEEK. Reset forces IDLE, Q=0, prescaler=0, synchronizer flops=0, and latched target=0. INC, Busy and Done are 0 during any cycle with Reset high.
- Priority per cycle: Reset > Goto > Run > Btn.
- IDLE: Goto goes to SEEK. Otherwise Run=1 goes to RUN, with the prescaler cleared on entry. Otherwise a synchronized Btn rising edge produces exactly one INC pulse.
- RUN: the prescaler counts 0..TICK_DIV-1 and wraps. INC is high for the cycle in which the prescaler equals TICK_DIV-1. Run=0 returns to IDLE on the next edge and clears the prescaler. Goto goes to SEEK with the prescaler held.
- SEEK: Target is latched on the Goto edge. INC = (Q != latched target), so the counter steps once per cycle with at most 3 steps. When Q equals the target, Done=1 for that cycle and the next edge leaves SEEK. The exit goes to RUN if Run=1, with the prescaler resuming from its held value; otherwise it goes to IDLE.
- Goto while in SEEK is ignored.
- Btn edges outside IDLE are discarded, not queued. The synchronizer keeps running, so a button held through SEEK or RUN does not fire on return to IDLE.
- Q increments mod 4 (3→0 wrap) on every edge where INC=1 and Reset=0.
- Busy = (state == SEEK).

## Timing
- Btn path: two-flop synchronizer followed by an edge flop, with the step pulse registered. If a Btn rise is first sampled at edge k, INC is high from k+2 to k+3 and Q updates at k+3.
- Run ticks: the first INC occurs TICK_DIV cycles after RUN entry, then one every TICK_DIV cycles.
- Seek: with Goto sampled at edge k, the seek takes N = (Target − Q) mod 4 cycles. INC is high for cycles k..k+N−1 (N consecutive cycles), Done is high in cycle k+N, and the state exits at edge k+N+1. If N=0, Done is high in the cycle after edge k and INC never asserts.
- Reset asserted mid-seek or mid-pulse: the next cycle shows IDLE, Q=0 and INC=0, with no partial step.

## Structure
- Shared package mod4_ctrl_pkg holds:
  - the state encodings (IDLE=2'd0, RUN=2'd1, SEEK=2'd2);
  - the count width constant (2);
  - the default TICK_DIV.
- Sub-module sync_edge: 2-flop synchronizer plus rising-edge pulse generator, with ports CLK, Reset, async_in, rise. It is reused by later board-input blocks.
- The top level contains the FSM, prescaler, shadow count and INC/Done logic.

## Test plan
- Reset, then Btn held high for 10 cycles starting at edge 5 -> exactly one INC during cycle 7–8, Q=1 at edge 8, and no further INC.
- Run=1 for 17 cycles with TICK_DIV=4 -> INC at prescaler=3 only, 4 INC pulses in total, Q wraps 0,1,2,3,0.
- From Q=0, Goto with Target=3 -> INC high for 3 consecutive cycles, Done one cycle after the last INC, Q=3, Busy low after exit. Goto with Target=3 again -> Done the next cycle with zero INC.
- Goto during RUN at prescaler=2 with Run held -> seek completes, return to RUN, and the next tick arrives 2 cycles after exit (prescaler resumed). Goto and a Btn edge arriving during SEEK -> both ignored.
- Reset pulsed in the middle of a seek from Q=1 toward Target=0 -> Q=0, IDLE, Busy=0 and Done=0, with no INC in the following cycle.

Source files
------------

// File: rtl/mod4_ctrl_pkg.sv
// Shared constants and state encoding for the mod-4 step controller family.
package mod4_ctrl_pkg;
  localparam int CNT_W        = 2;
  localparam int TICK_DIV_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEEK = 2'd2
  } state_t;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer, edge flop and registered one-cycle rise pulse.
// Latency: rise is high two edges after the input is first sampled high.
module sync_edge (
  input  logic CLK,
  input  logic Reset,
  input  logic async_in,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end
endmodule

// File: rtl/mod4_step_ctrl.sv
// Generates the mod-4 counter INC strobe from button, free-run tick and seek,
// and keeps a shadow of the count. Priority: Reset > Goto > Run > Btn.
module mod4_step_ctrl
  import mod4_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Btn,
  input  logic             Run,
  input  logic             Goto,
  input  logic [CNT_W-1:0] Target,
  output logic             INC,
  output logic [CNT_W-1:0] Q,
  output logic             Busy,
  output logic             Done
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t           state, state_nxt;
  logic [PW-1:0]    pre, pre_nxt;
  logic [CNT_W-1:0] tgt, tgt_nxt;
  logic             btn_rise;

  sync_edge u_btn (
    .CLK      (CLK),
    .Reset    (Reset),
    .async_in (Btn),
    .rise     (btn_rise)
  );

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    tgt_nxt   = tgt;
    INC       = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Goto) begin
          state_nxt = SEEK;
          tgt_nxt   = Target;
        end else if (Run) begin
          state_nxt = RUN;
          pre_nxt   = '0;
        end else begin
          INC = btn_rise;
        end
      end
      RUN: begin
        // Prescaler is held across a seek so the tick cadence resumes afterwards.
        if (Goto) begin
          state_nxt = SEEK;
          tgt_nxt   = Target;
        end else if (!Run) begin
          state_nxt = IDLE;
          pre_nxt   = '0;
        end else begin
          INC     = (pre == PRE_LAST);
          pre_nxt = (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
      end
      SEEK: begin
        if (Q == tgt) begin
          Done      = 1'b1;
          state_nxt = Run ? RUN : IDLE;
        end else begin
          INC = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (Reset) begin
      INC  = 1'b0;
      Done = 1'b0;
    end
  end

  assign Busy = (state == SEEK) && !Reset;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      pre   <= '0;
      tgt   <= '0;
      Q     <= '0;
    end else begin
      state <= state_nxt;
      pre   <= pre_nxt;
      tgt   <= tgt_nxt;
      Q     <= Q + CNT_W'(INC);
    end
  end
endmodule

// File: tb/tb_mod4_step_ctrl.sv
// Directed plus random bench for mod4_step_ctrl against a cycle-level reference model.
module tb_mod4_step_ctrl;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, btn, run, go;
  logic [1:0] target;
  logic       inc, busy, done;
  logic [1:0] q;

  int n_assert = 0;
  int n_fail   = 0;
  int inc_seen = 0;

  // Reference model: mode 0=idle, 1=run, 2=seek; seek tracks steps remaining.
  int m_mode, m_q, m_phase, m_left;
  bit m_h [4];
  bit e_inc, e_done, e_busy;

  mod4_step_ctrl #(.TICK_DIV(TD)) dut (
    .CLK    (clk),
    .Reset  (rst),
    .Btn    (btn),
    .Run    (run),
    .Goto   (go),
    .Target (target),
    .INC    (inc),
    .Q      (q),
    .Busy   (busy),
    .Done   (done)
  );

  initial forever #5 clk = ~clk;

  function void model_eval();
    e_inc  = 1'b0;
    e_done = 1'b0;
    e_busy = 1'b0;
    if (!rst) begin
      if (m_mode == 0) begin
        if (!go && !run) e_inc = m_h[2] && !m_h[3];
      end else if (m_mode == 1) begin
        if (!go && run) e_inc = (m_phase == TD - 1);
      end else begin
        e_busy = 1'b1;
        e_inc  = (m_left > 0);
        e_done = (m_left == 0);
      end
    end
  endfunction

  function void model_edge();
    if (rst) begin
      m_mode = 0; m_q = 0; m_phase = 0; m_left = 0;
      for (int i = 0; i < 4; i++) m_h[i] = 1'b0;
    end else begin
      for (int i = 3; i > 0; i--) m_h[i] = m_h[i-1];
      m_h[0] = btn;
      if (e_inc) m_q = (m_q + 1) % 4;
      if (m_mode == 2) begin
        if (e_inc) m_left = m_left - 1;
        else m_mode = run ? 1 : 0;
      end else if (go) begin
        m_mode = 2;
        m_left = (int'(target) - m_q + 4) % 4;
      end else if (m_mode == 1) begin
        if (!run) begin
          m_mode = 0; m_phase = 0;
        end else begin
          m_phase = (m_phase + 1) % TD;
        end
      end else if (run) begin
        m_mode = 1; m_phase = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    logic [1:0] mq;
    @(negedge clk);
    model_eval();
    mq = 2'(m_q);
    chk({tag, "_inc"},  8'(inc),  8'(e_inc));
    chk({tag, "_q"},    8'(q),    8'(mq));
    chk({tag, "_busy"}, 8'(busy), 8'(e_busy));
    chk({tag, "_done"}, 8'(done), 8'(e_done));
    if (inc === 1'b1) inc_seen++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; run = 1'b0; go = 1'b0; target = 2'd0;
    model_edge();
    @(posedge clk);
    #1;
    repeat (2) step("reset");
    rst = 1'b0;
    step("idle");

    // Held button gives exactly one step.
    btn = 1'b1; inc_seen = 0;
    repeat (10) step("btn");
    btn = 1'b0;
    repeat (4) step("btn_rel");
    chk("btn_count", 8'(inc_seen), 8'd1);
    chk("btn_q", 8'(q), 8'd1);

    // Free-run for 17 cycles from Q=0.
    rst = 1'b1; step("rst2"); rst = 1'b0;
    run = 1'b1; inc_seen = 0;
    repeat (17) step("run");
    run = 1'b0;
    step("run_off");
    chk("run_count", 8'(inc_seen), 8'd4);
    chk("run_q", 8'(q), 8'd0);

    // Seek 0 -> 3, then a zero-length seek.
    target = 2'd3; go = 1'b1; inc_seen = 0;
    step("goto3");
    go = 1'b0;
    repeat (5) step("seek3");
    chk("seek_count", 8'(inc_seen), 8'd3);
    chk("seek_q", 8'(q), 8'd3);
    chk("seek_busy_after", 8'(busy), 8'd0);
    go = 1'b1; inc_seen = 0;
    step("goto3b");
    go = 1'b0;
    repeat (3) step("seek0");
    chk("seek0_count", 8'(inc_seen), 8'd0);

    // Goto at prescaler=2 during run; Goto and Btn during seek are ignored.
    run = 1'b1;
    repeat (3) step("run_pre");
    target = 2'd1; go = 1'b1;
    step("run_goto");
    go = 1'b0; btn = 1'b1;
    step("seek_btn");
    go = 1'b1; target = 2'd0;
    step("seek_goto");
    go = 1'b0; btn = 1'b0;
    repeat (10) step("seek_run");
    run = 1'b0;
    repeat (2) step("run_stop");

    // Reset mid-seek from Q=1 toward 0.
    rst = 1'b1; step("rst3"); rst = 1'b0;
    btn = 1'b1;
    repeat (4) step("btn2");
    btn = 1'b0;
    step("btn2_rel");
    chk("pre_seek_q", 8'(q), 8'd1);
    target = 2'd0; go = 1'b1;
    step("goto0");
    go = 1'b0;
    step("seek_mid");
    rst = 1'b1;
    step("rst_seek");
    rst = 1'b0;
    step("after_rst");
    chk("rst_seek_q", 8'(q), 8'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      go     = ($urandom_range(0, 9) == 0);
      target = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
